stream_minmax_tracker: RTL and testbench

//  Streaming successor to the combinational min/max selector. Accepts one

---
 rtl/stream_minmax_tracker.sv | 137 +++++++++++++
 tb/tb_stream_minmax_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_minmax_tracker.sv
// Purpose : streaming running min/max tracker; closes a frame at FRAME_LEN samples
//           or on in_last, then holds min, max and sample count for the consumer.
// Latency : out_valid rises 1 cycle after the closing accept.
// Backpr. : in_ready=0 while a result is held; released the cycle out_valid drops.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last   sample stream in (valid/ready)
//   out_valid/out_ready            frame result handshake
//   out_min/out_max/out_count      frame minimum, maximum, number of samples
//   out_min_idx/out_max_idx        zero-based first-occurrence positions, present
//                                  only when STREAM_MINMAX_ARGIDX_EN is defined
//
// SIGNED=1 compares as two's complement. Sample values are stored and passed
// through unchanged in both modes.

module stream_minmax_tracker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int SIGNED    = 0,
    localparam int CW       = $clog2(FRAME_LEN + 1),
    localparam int IW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
`ifdef STREAM_MINMAX_ARGIDX_EN
    output logic [IW-1:0]    out_min_idx,
    output logic [IW-1:0]    out_max_idx,
`endif
    output logic [CW-1:0]    out_count
);

    typedef enum logic [1:0] {
        ACC_EMPTY = 2'd0,
        ACC       = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t state;

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0)
            return $signed(a) < $signed(b);
        else
            return a < b;
    endfunction

    // State is registered, so in_ready is a clean decode with no input path.
    assign in_ready = (state != HOLD);

    logic new_min;
    logic new_max;
    logic closing_acc;

    always_comb begin
        new_min     = less(in_data, out_min);
        new_max     = less(out_max, in_data);
        // In ACC the stored count is the number of samples already taken, so
        // the incoming sample is the last one when count == FRAME_LEN-1.
        closing_acc = in_last || (out_count == CW'(FRAME_LEN - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC_EMPTY;
            out_valid <= 1'b0;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
`ifdef STREAM_MINMAX_ARGIDX_EN
            out_min_idx <= '0;
            out_max_idx <= '0;
`endif
        end else begin
            case (state)
                ACC_EMPTY: begin
                    if (in_valid) begin
                        out_min   <= in_data;
                        out_max   <= in_data;
                        out_count <= CW'(1);
`ifdef STREAM_MINMAX_ARGIDX_EN
                        out_min_idx <= '0;
                        out_max_idx <= '0;
`endif
                        if (in_last || (FRAME_LEN == 1)) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        // Strict compares: ties keep the earlier sample.
                        if (new_min) begin
                            out_min <= in_data;
`ifdef STREAM_MINMAX_ARGIDX_EN
                            out_min_idx <= out_count[IW-1:0];
`endif
                        end
                        if (new_max) begin
                            out_max <= in_data;
`ifdef STREAM_MINMAX_ARGIDX_EN
                            out_max_idx <= out_count[IW-1:0];
`endif
                        end
                        out_count <= out_count + CW'(1);
                        if (closing_acc) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACC_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACC_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_minmax_tracker.sv
module tb_stream_minmax_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Unsigned and signed L=4 instances share one input stream.
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = '0;
    logic       in_last  = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy_u, vld_u, rdy_s, vld_s;
    logic [7:0] min_u, max_u, min_s, max_s;
    logic [2:0] cnt_u, cnt_s;
    logic [1:0] mni_u, mxi_u, mni_s, mxi_s;

    // FRAME_LEN=1 instance.
    logic       v1 = 1'b0;
    logic [7:0] d1 = '0;
    logic       or1 = 1'b1;
    logic       rdy_1, vld_1;
    logic [7:0] min_1, max_1;
    logic [0:0] cnt_1, mni_1, mxi_1;

    stream_minmax_tracker #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u), .in_data(in_data),
        .in_last(in_last), .out_valid(vld_u), .out_ready(out_ready), .out_min(min_u),
        .out_max(max_u),
`ifdef STREAM_MINMAX_ARGIDX_EN
        .out_min_idx(mni_u), .out_max_idx(mxi_u),
`endif
        .out_count(cnt_u));

    stream_minmax_tracker #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
        .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready), .out_min(min_s),
        .out_max(max_s),
`ifdef STREAM_MINMAX_ARGIDX_EN
        .out_min_idx(mni_s), .out_max_idx(mxi_s),
`endif
        .out_count(cnt_s));

    stream_minmax_tracker #(.WIDTH(8), .FRAME_LEN(1), .SIGNED(0)) dut_1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy_1), .in_data(d1),
        .in_last(1'b0), .out_valid(vld_1), .out_ready(or1), .out_min(min_1),
        .out_max(max_1),
`ifdef STREAM_MINMAX_ARGIDX_EN
        .out_min_idx(mni_1), .out_max_idx(mxi_1),
`endif
        .out_count(cnt_1));

`ifndef STREAM_MINMAX_ARGIDX_EN
    assign {mni_u, mxi_u, mni_s, mxi_s, mni_1, mxi_1} = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] frame_q[$];

    // Reference: scan the frame, keep the first occurrence of the extreme value.
    task automatic model(input bit sgn, output int mni, output int mxi);
        int best_lo, best_hi, v;
        mni = 0; mxi = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            v = sgn ? int'(frame_q[i]) - (frame_q[i][7] ? 256 : 0) : int'(frame_q[i]);
            if (i == 0) begin
                best_lo = v; best_hi = v;
            end else begin
                if (v < best_lo) begin best_lo = v; mni = i; end
                if (v > best_hi) begin best_hi = v; mxi = i; end
            end
        end
    endtask

    // Offer one sample; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] d, input bit l);
        int guard;
        in_valid = 1'b1; in_data = d; in_last = l;
        guard = 0;
        while (!rdy_u && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Send frame_q (in_last on final sample when short), check result, drain.
    task automatic play_frame(input int hold);
        int n, ui_mn, ui_mx, si_mn, si_mx;
        logic [7:0] smin, smax;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            send(frame_q[i], (i == n - 1) && (n < 4));
            if (i < n - 1) chk("no_early_vld", {31'd0, vld_u}, 0);
        end
        model(1'b0, ui_mn, ui_mx);
        model(1'b1, si_mn, si_mx);
        chk("vld_u", {31'd0, vld_u}, 1);
        chk("vld_s", {31'd0, vld_s}, 1);
        chk("rdy_hold", {31'd0, rdy_u}, 0);
        chk("min_u", {24'd0, min_u}, {24'd0, frame_q[ui_mn]});
        chk("max_u", {24'd0, max_u}, {24'd0, frame_q[ui_mx]});
        chk("cnt_u", {29'd0, cnt_u}, n);
        chk("min_s", {24'd0, min_s}, {24'd0, frame_q[si_mn]});
        chk("max_s", {24'd0, max_s}, {24'd0, frame_q[si_mx]});
        chk("cnt_s", {29'd0, cnt_s}, n);
`ifdef STREAM_MINMAX_ARGIDX_EN
        chk("mni_u", {30'd0, mni_u}, ui_mn);
        chk("mxi_u", {30'd0, mxi_u}, ui_mx);
        chk("mni_s", {30'd0, mni_s}, si_mn);
        chk("mxi_s", {30'd0, mxi_s}, si_mx);
`endif
        smin = min_u; smax = max_u;
        in_valid = 1'b1;
        for (int c = 0; c < hold; c++) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_vld", {31'd0, vld_u}, 1);
            chk("hold_rdy", {31'd0, rdy_u}, 0);
            chk("hold_min", {24'd0, min_u}, {24'd0, smin});
            chk("hold_max", {24'd0, max_u}, {24'd0, smax});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_vld", {31'd0, vld_u}, 0);
        chk("drain_rdy", {31'd0, rdy_u}, 1);
    endtask

    initial begin
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_vld", {31'd0, vld_u}, 0);
        chk("rst_rdy", {31'd0, rdy_u}, 1);
        chk("rst_min", {24'd0, min_u}, 0);
        chk("rst_max", {24'd0, max_u}, 0);
        chk("rst_cnt", {29'd0, cnt_u}, 0);
        chk("rst_vld1", {31'd0, vld_1}, 0);

        frame_q = '{8'd5, 8'd9, 8'd2, 8'd7};               play_frame(0);
        chk("t1_min", {24'd0, min_u}, 2);
        frame_q = '{8'hF0, 8'h10, 8'h80, 8'h7F};           play_frame(0);
        chk("t2_smin", {24'd0, min_s}, 32'h80);
        chk("t2_smax", {24'd0, max_s}, 32'h7F);
        frame_q = '{8'd3, 8'd3};                           play_frame(0);
        frame_q = '{8'd1, 8'd200, 8'd50, 8'd4};            play_frame(5);

        // Reset mid-frame: partial frame must vanish.
        send(8'd9, 1'b0);
        send(8'd0, 1'b0);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_vld", {31'd0, vld_u}, 0);
        chk("mid_rst_rdy", {31'd0, rdy_u}, 1);
        chk("mid_rst_cnt", {29'd0, cnt_u}, 0);
        frame_q = '{8'd1, 8'd1, 8'd1, 8'd1};               play_frame(1);

        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 4);
            frame_q.delete();
            for (int i = 0; i < len; i++)
                frame_q.push_back(($urandom_range(0, 3) == 0) ? 8'd7 : 8'($urandom));
            play_frame($urandom_range(0, 3));
        end

        // FRAME_LEN=1, back-to-back samples with consumer always ready.
        v1 = 1'b1; d1 = 8'd4;
        @(posedge clk); #1;
        chk("l1_vld_a", {31'd0, vld_1}, 1);
        chk("l1_min_a", {24'd0, min_1}, 4);
        chk("l1_max_a", {24'd0, max_1}, 4);
        chk("l1_cnt_a", {31'd0, cnt_1}, 1);
        chk("l1_rdy_a", {31'd0, rdy_1}, 0);
        d1 = 8'd6;
        @(posedge clk); #1;
        chk("l1_bubble", {31'd0, vld_1}, 0);
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("l1_vld_b", {31'd0, vld_1}, 1);
        chk("l1_min_b", {24'd0, min_1}, 6);
        chk("l1_max_b", {24'd0, max_1}, 6);
        chk("l1_cnt_b", {31'd0, cnt_1}, 1);
        @(posedge clk); #1;
        chk("l1_idle", {31'd0, vld_1}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
